// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with single-cycle logic ops and iterative mul/div.
// Define SEQ_ALU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [3:0]       alu_op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_data_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    state_t           issue_state;
    logic             accept;
    logic             is_iter;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == DONE);
    assign alu_data_o  = data_q;
    assign shamt       = operand_b_i[SHW-1:0];

    always_comb begin
        simple_res = '0;
        unique case (alu_op_i)
            4'd0:    simple_res = operand_a_i + operand_b_i;
            4'd1:    simple_res = operand_a_i - operand_b_i;
            4'd2:    simple_res = {{(WIDTH-1){1'b0}},
                                   $signed(operand_a_i) < $signed(operand_b_i)};
            4'd3:    simple_res = {{(WIDTH-1){1'b0}}, operand_a_i < operand_b_i};
            4'd4:    simple_res = operand_a_i ^ operand_b_i;
            4'd5:    simple_res = operand_a_i | operand_b_i;
            4'd6:    simple_res = operand_a_i & operand_b_i;
            4'd7:    simple_res = operand_a_i << shamt;
            4'd8:    simple_res = operand_a_i >> shamt;
            4'd9:    simple_res = $signed(operand_a_i) >>> shamt;
            default: simple_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // acc_q is the product high half / partial remainder,
    // lo_q the multiplier / dividend that shifts into the quotient.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;
    logic [1:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH-1:0] iter_res;

    assign is_iter = (alu_op_i >= 4'd10) && (alu_op_i <= 4'd13);
    assign last    = (cnt_q == SHW'(WIDTH - 1));
    assign busy_o  = (state_q == CALC);

    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q, lo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opb_q};
        acc_n   = '0;
        lo_n    = '0;
        if (op_q[1]) begin
            acc_n = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_n  = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        // MULHU and REMU take the upper register, MUL and DIVU the lower.
        iter_res = op_q[0] ? acc_n : lo_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else if (accept && is_iter) begin
            acc_q <= '0;
            lo_q  <= operand_a_i;
            opb_q <= operand_b_i;
            op_q  <= alu_op_i[1:0] - 2'd2;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign issue_state = is_iter ? CALC : DONE;
`else
    assign is_iter     = 1'b0;
    assign busy_o      = 1'b0;
    assign issue_state = DONE;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (accept && !is_iter) begin
            data_q <= simple_res;
`ifdef SEQ_ALU_MULDIV_EN
        end else if ((state_q == CALC) && last) begin
            data_q <= iter_res;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = issue_state;
            end
`ifdef SEQ_ALU_MULDIV_EN
            CALC: begin
                if (last) state_d = DONE;
            end
`endif
            DONE: begin
                if (accept) state_d = issue_state;
                else if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL provide derived localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL provide port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL provide port in_valid_i, input, 1 bit: the operation request is valid.
REQ-006 SHALL provide port in_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL provide port operand_a_i, input, WIDTH bits: first operand.
REQ-008 SHALL provide port operand_b_i, input, WIDTH bits: second operand.
REQ-009 SHALL provide port alu_op_i, input, 4 bits: operation select.
REQ-010 SHALL provide port out_valid_o, output, 1 bit: alu_data_o holds a valid result.
REQ-011 SHALL provide port out_ready_i, input, 1 bit: the consumer takes the result.
REQ-012 SHALL provide port alu_data_o, output, WIDTH bits: registered result.
REQ-013 SHALL provide port busy_o, output, 1 bit: an iterative operation is in progress.

Function
REQ-014 SHALL accept a request when in_valid_i and in_ready_o are both high, capturing the operands and alu_op_i.
REQ-015 SHALL decode alu_op_i as:
- 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 XOR, 5 OR, 6 AND;
- 7 SLL, 8 SRL, 9 SRA, each shifting by operand_b_i[SHW-1:0];
- 10 MUL (low WIDTH bits of the product), 11 MULHU (high WIDTH bits of the unsigned product), 12 DIVU, 13 REMU;
- 14 and 15 return 0.
REQ-016 SHALL compute all arithmetic modulo 2^WIDTH; SLT and SLTU return a 0 or 1 zero-extended to WIDTH; SRA sign-fills from operand_a_i[WIDTH-1].
REQ-017 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-018 SHALL, for ops 0-9 and 14-15, move IDLE->DONE on acceptance, with the result registered and out_valid_o high on the next cycle (latency 1).
REQ-019 SHALL, for ops 10-13, move IDLE->CALC on acceptance and run exactly WIDTH iterations (shift-add multiply, restoring divide), then move CALC->DONE; out_valid_o rises WIDTH+1 cycles after acceptance.
REQ-020 SHALL drive in_ready_o high in IDLE, and in DONE when out_ready_i is high (back-to-back issue); in_ready_o SHALL be low in CALC.
REQ-021 SHALL move DONE->IDLE when out_ready_i is high and no new request is accepted; DONE with simultaneous acceptance follows REQ-018/REQ-019 directly.
REQ-022 SHALL hold alu_data_o and out_valid_o stable while out_valid_o is high and out_ready_i is low.
REQ-023 SHALL make DIVU by zero return all ones and REMU by zero return operand_a.
REQ-024 SHALL drive busy_o high exactly while in the CALC state.
REQ-025 SHALL ignore in_valid_i while in_ready_o is low; no request is queued or lost-acknowledged.

Reset
REQ-026 SHALL, on rst_i high, immediately force state to IDLE, out_valid_o=0, alu_data_o=0, busy_o=0 and in_ready_o=1 after release.
REQ-027 SHALL, on reset asserted mid-CALC, abort the operation and produce no result after release.

Configuration
REQ-028 SHALL, when macro SEQ_ALU_MULDIV_EN is defined, implement ops 10-13 as specified in REQ-019 and REQ-023.
REQ-029 SHALL, when SEQ_ALU_MULDIV_EN is undefined, omit the CALC state and iterative datapath, treat ops 10-13 as single-cycle ops returning 0, and tie busy_o to 0.

Verification
REQ-030 Bench SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1 -> alu_data_o=0, out_valid_o one cycle after acceptance.
REQ-031 Bench SHALL cover: SRA a=0x80000000, b=4 -> 0xF8000000; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-032 Bench SHALL cover: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, with busy_o high for 32 cycles and in_ready_o low throughout.
REQ-033 Bench SHALL cover: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/7 -> 2.
REQ-034 Bench SHALL cover: out_ready_i low for 5 cycles -> result held; then out_ready_i high with a new ADD presented in the same cycle -> accepted back-to-back.
REQ-035 Bench SHALL cover: rst_i pulsed at CALC iteration 10 -> outputs 0 immediately, no out_valid_o afterwards, next request processed normally.
